vertex_ingress_queue: RTL and testbench

//   Consumes the per-point vertex words (x/y/z/w/colour + point trigger) written by the processor's

---
 rtl/gpu_pipe_pkg.sv | 13 +
 rtl/vtx_fifo_ram.sv | 25 ++
 rtl/vertex_ingress_queue.sv | 128 ++++++++++++
 tb/tb_vertex_ingress_queue.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pipe_pkg.sv
// Vertex format shared between the ingress queue and the matrix-transform pipeline.
package gpu_pipe_pkg;
  localparam int COORD_W = 32;
  localparam int COLOR_W = 18;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] z;
    logic [COORD_W-1:0] w;
    logic [COLOR_W-1:0] color;
  } vertex_t;
endpackage

// File: rtl/vtx_fifo_ram.sv
// Simple dual-port vertex storage: one write port, one registered read port.
module vtx_fifo_ram
  import gpu_pipe_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  vertex_t           wdata,
  input  logic [ADDR_W-1:0] raddr,
  output vertex_t           rdata
);

  vertex_t mem [DEPTH];

  // NOTE: storage and its read register carry no reset so they map onto block RAM;
  // the pointers and valid flags in the parent decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/vertex_ingress_queue.sv
// First-word-fall-through vertex queue between register_control and the transform stage.
module vertex_ingress_queue
  import gpu_pipe_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                gpu_enable_i,
  input  logic                point_trig_i,
  input  logic [COORD_W-1:0]  x_in_i,
  input  logic [COORD_W-1:0]  y_in_i,
  input  logic [COORD_W-1:0]  z_in_i,
  input  logic [COORD_W-1:0]  w_in_i,
  input  logic [COLOR_W-1:0]  color_in_i,
  output logic                vtx_valid_o,
  input  logic                vtx_ready_i,
  output logic [COORD_W-1:0]  vtx_x_o,
  output logic [COORD_W-1:0]  vtx_y_o,
  output logic [COORD_W-1:0]  vtx_z_o,
  output logic [COORD_W-1:0]  vtx_w_o,
  output logic [COLOR_W-1:0]  vtx_color_o,
  output logic [ADDR_W:0]     fifo_count_o,
  output logic                full_o,
  output logic                overflow_o,
  input  logic                clear_ovf_i,
  output logic [CNT_W-1:0]    vtx_count_o
);

  logic              trig_q, en_q;
  logic [ADDR_W:0]   count;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic              out_valid, fwd_valid, overflow;
  logic [CNT_W-1:0]  vtx_count;
  vertex_t           out_data, fwd_data, ram_q, head_data, in_vtx;
  logic push_req, pop, full, push, drop, out_free, ram_empty, load_ram, load_direct, ram_we;

  assign in_vtx = {x_in_i, y_in_i, z_in_i, w_in_i, color_in_i};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    push_req    = point_trig_i & ~trig_q & gpu_enable_i;
    pop         = out_valid & vtx_ready_i;
    full        = (count == (ADDR_W+1)'(DEPTH));
    push        = push_req & (~full | pop);
    drop        = push_req & full & ~pop;
    out_free    = ~out_valid | pop;
    ram_empty   = (count == {{ADDR_W{1'b0}}, out_valid});
    load_ram    = out_free & ~ram_empty;
    load_direct = out_free & ram_empty & push;
    ram_we      = push & ~load_direct;
    rd_ptr_nxt  = gpu_enable_i ? rd_ptr + ADDR_W'(load_ram) : '0;
    // A write landing on the address being read this edge leaves ram_q stale for one cycle.
    head_data   = fwd_valid ? fwd_data : ram_q;
  end

  vtx_fifo_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk   (sys_clk),
    .we    (ram_we),
    .waddr (wr_ptr),
    .wdata (in_vtx),
    .raddr (rd_ptr_nxt),
    .rdata (ram_q)
  );

  // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      trig_q    <= 1'b0;
      en_q      <= 1'b0;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      fwd_valid <= 1'b0;
      fwd_data  <= '0;
      overflow  <= 1'b0;
      vtx_count <= '0;
    end else begin
      trig_q   <= point_trig_i;
      en_q     <= gpu_enable_i;
      fwd_data <= in_vtx;

      if (drop)             overflow <= 1'b1;
      else if (clear_ovf_i) overflow <= 1'b0;

      if (gpu_enable_i && !en_q) vtx_count <= CNT_W'(push);
      else if (push)             vtx_count <= vtx_count + 1'b1;

      if (!gpu_enable_i) begin
        count     <= '0;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        out_valid <= 1'b0;
        fwd_valid <= 1'b0;
      end else begin
        count     <= count + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
        wr_ptr    <= wr_ptr + ADDR_W'(ram_we);
        rd_ptr    <= rd_ptr_nxt;
        fwd_valid <= ram_we && (wr_ptr == rd_ptr_nxt);
        if (load_ram) begin
          out_data  <= head_data;
          out_valid <= 1'b1;
        end else if (load_direct) begin
          out_data  <= in_vtx;
          out_valid <= 1'b1;
        end else if (pop) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

  assign vtx_valid_o  = out_valid;
  assign vtx_x_o      = out_data.x;
  assign vtx_y_o      = out_data.y;
  assign vtx_z_o      = out_data.z;
  assign vtx_w_o      = out_data.w;
  assign vtx_color_o  = out_data.color;
  assign fifo_count_o = count;
  assign full_o       = full;
  assign overflow_o   = overflow;
  assign vtx_count_o  = vtx_count;

endmodule

// File: tb/tb_vertex_ingress_queue.sv
// Self-checking bench: directed vector table, hand-written corner sequences, random run vs queue model.
module tb_vertex_ingress_queue;
  import gpu_pipe_pkg::*;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 16;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               en, trig, ready, clr;
  logic [COORD_W-1:0] x_in, y_in, z_in, w_in;
  logic [COLOR_W-1:0] color_in;
  logic               valid, full, ovf;
  logic [COORD_W-1:0] vx, vy, vz, vw;
  logic [COLOR_W-1:0] vcolor;
  logic [ADDR_W:0]    fcount;
  logic [CNT_W-1:0]   vcount;

  always #5 clk = ~clk;

  vertex_ingress_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .sys_clk      (clk),
    .sys_rst_n    (rst_n),
    .gpu_enable_i (en),
    .point_trig_i (trig),
    .x_in_i       (x_in),
    .y_in_i       (y_in),
    .z_in_i       (z_in),
    .w_in_i       (w_in),
    .color_in_i   (color_in),
    .vtx_valid_o  (valid),
    .vtx_ready_i  (ready),
    .vtx_x_o      (vx),
    .vtx_y_o      (vy),
    .vtx_z_o      (vz),
    .vtx_w_o      (vw),
    .vtx_color_o  (vcolor),
    .fifo_count_o (fcount),
    .full_o       (full),
    .overflow_o   (ovf),
    .clear_ovf_i  (clr),
    .vtx_count_o  (vcount)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: a queue of vertices plus the sticky flag and the accepted counter.
  vertex_t mq[$];
  logic    m_ovf;
  int      m_vcnt;
  logic    m_trig_prev, m_en_prev;

  task automatic model_step();
    logic    rise, pop, accepted, dropped;
    vertex_t v;
    v        = {x_in, y_in, z_in, w_in, color_in};
    rise     = trig && !m_trig_prev && en;
    pop      = en && (mq.size() > 0) && ready;
    accepted = 1'b0;
    dropped  = 1'b0;
    if (!en) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (rise) begin
        if (mq.size() < DEPTH) begin
          mq.push_back(v);
          accepted = 1'b1;
        end else dropped = 1'b1;
      end
    end
    if (en && !m_en_prev) m_vcnt = accepted ? 1 : 0;
    else if (accepted)    m_vcnt = (m_vcnt + 1) % (1 << CNT_W);
    if (dropped)  m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    m_trig_prev = trig;
    m_en_prev   = en;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check_model();
    check("m_valid", 64'(valid), 64'(mq.size() > 0));
    check("m_count", 64'(fcount), 64'(mq.size()));
    check("m_full", 64'(full), 64'(mq.size() == DEPTH));
    check("m_ovf", 64'(ovf), 64'(m_ovf));
    check("m_vcnt", 64'(vcount), 64'(m_vcnt));
    if (mq.size() > 0) begin
      check("m_xy", {vx, vy}, {mq[0].x, mq[0].y});
      check("m_zw", {vz, vw}, {mq[0].z, mq[0].w});
      check("m_color", 64'(vcolor), 64'(mq[0].color));
    end
  endtask

  task automatic push_one(input logic [COORD_W-1:0] xv);
    x_in = xv; y_in = ~xv; z_in = xv ^ 32'h5A5A_5A5A; w_in = xv + 32'd7;
    color_in = xv[COLOR_W-1:0];
    trig = 1'b1; step();
    trig = 1'b0; step();
  endtask

  typedef struct {
    logic               en, trig, ready;
    logic [COORD_W-1:0] x;
    logic [COLOR_W-1:0] color;
    logic               exp_valid;
    logic [COORD_W-1:0] exp_x;
    logic [COLOR_W-1:0] exp_color;
    int                 exp_count;
    int                 exp_vcnt;
  } vec_t;

  function automatic vec_t mk(input logic e, input logic t, input logic r,
                              input logic [COORD_W-1:0] xv, input logic [COLOR_W-1:0] cv,
                              input logic ev, input logic [COORD_W-1:0] ex,
                              input logic [COLOR_W-1:0] ec, input int cnt, input int vc);
    vec_t v;
    v.en = e; v.trig = t; v.ready = r; v.x = xv; v.color = cv;
    v.exp_valid = ev; v.exp_x = ex; v.exp_color = ec; v.exp_count = cnt; v.exp_vcnt = vc;
    return v;
  endfunction

  vec_t vecs[14];

  initial begin
    // Single push/pop, then a trigger held high for ten cycles.
    vecs[0] = mk(1, 0, 0, 32'h0, 18'h0, 0, 32'h0, 18'h0, 0, 0);
    vecs[1] = mk(1, 1, 0, 32'h3F80_0000, 18'h3FFFF, 1, 32'h3F80_0000, 18'h3FFFF, 1, 1);
    vecs[2] = mk(1, 0, 1, 32'h0, 18'h0, 0, 32'h0, 18'h0, 0, 1);
    for (int i = 3; i < 13; i++)
      vecs[i] = mk(1, 1, 0, 32'h11, 18'h155, 1, 32'h11, 18'h155, 1, 2);
    vecs[13] = mk(1, 0, 1, 32'h0, 18'h0, 0, 32'h0, 18'h0, 0, 2);

    rst_n = 1'b0; en = 1'b0; trig = 1'b0; ready = 1'b0; clr = 1'b0;
    x_in = '0; y_in = '0; z_in = '0; w_in = '0; color_in = '0;
    mq.delete(); m_ovf = 1'b0; m_vcnt = 0; m_trig_prev = 1'b0; m_en_prev = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_count", 64'(fcount), 64'd0);
    check("rst_full", 64'(full), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_vcnt", 64'(vcount), 64'd0);
    check("rst_data", {vx, 14'd0, vcolor}, 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      en = vecs[i].en; trig = vecs[i].trig; ready = vecs[i].ready;
      x_in = vecs[i].x; color_in = vecs[i].color; y_in = '0; z_in = '0; w_in = '0;
      step();
      check($sformatf("vec%0d_valid", i), 64'(valid), 64'(vecs[i].exp_valid));
      check($sformatf("vec%0d_count", i), 64'(fcount), 64'(vecs[i].exp_count));
      check($sformatf("vec%0d_vcnt", i), 64'(vcount), 64'(vecs[i].exp_vcnt));
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d_x", i), 64'(vx), 64'(vecs[i].exp_x));
        check($sformatf("vec%0d_color", i), 64'(vcolor), 64'(vecs[i].exp_color));
      end
    end
    trig = 1'b0; ready = 1'b0;

    // Fill past full, clear the sticky flag, drain in order.
    en = 1'b0; step();
    en = 1'b1; step();
    check("t3_vcnt_clr", 64'(vcount), 64'd0);
    for (int i = 1; i <= 17; i++) push_one(32'(i));
    check("t3_full", 64'(full), 64'd1);
    check("t3_count", 64'(fcount), 64'd16);
    check("t3_ovf", 64'(ovf), 64'd1);
    check("t3_vcnt", 64'(vcount), 64'd16);
    clr = 1'b1; step(); clr = 1'b0;
    check("t3_ovf_clr", 64'(ovf), 64'd0);
    check("t3_count_kept", 64'(fcount), 64'd16);
    ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      check($sformatf("t3_drain%0d", i), 64'(vx), 64'(i));
      step();
    end
    ready = 1'b0;
    check("t3_empty", 64'(fcount), 64'd0);
    check("t3_valid0", 64'(valid), 64'd0);

    // Push coincident with a pop while full is accepted.
    for (int i = 0; i < 16; i++) push_one(32'(100 + i));
    check("t4_count_pre", 64'(fcount), 64'd16);
    x_in = 32'd200; trig = 1'b1; ready = 1'b1; step();
    trig = 1'b0; ready = 1'b0;
    check("t4_count", 64'(fcount), 64'd16);
    check("t4_ovf", 64'(ovf), 64'd0);
    check("t4_head", 64'(vx), 64'd101);
    check("t4_vcnt", 64'(vcount), 64'd33);
    ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      check_model();
    end
    ready = 1'b0;
    check("t4_empty", 64'(fcount), 64'd0);

    // Flush with a stalled head and overflow set; re-enable clears only the counter.
    for (int i = 0; i < 17; i++) push_one(32'(300 + i));
    check("t5_ovf_set", 64'(ovf), 64'd1);
    ready = 1'b1;
    repeat (11) step();
    ready = 1'b0;
    check("t5_count5", 64'(fcount), 64'd5);
    en = 1'b0; step();
    check("t5_flush_count", 64'(fcount), 64'd0);
    check("t5_flush_valid", 64'(valid), 64'd0);
    check("t5_flush_ovf", 64'(ovf), 64'd1);
    check("t5_flush_vcnt", 64'(vcount), 64'd49);
    en = 1'b1; step();
    check("t5_reen_vcnt", 64'(vcount), 64'd0);
    check("t5_reen_ovf", 64'(ovf), 64'd1);
    clr = 1'b1; step(); clr = 1'b0;
    check_model();

    // Random traffic against the reference model.
    for (int c = 0; c < 10000; c++) begin
      trig     = 1'($urandom_range(0, 1));
      ready    = (c < 5000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      en       = ($urandom_range(0, 127) != 0);
      clr      = ($urandom_range(0, 31) == 0);
      x_in     = $urandom; y_in = $urandom; z_in = $urandom; w_in = $urandom;
      color_in = COLOR_W'($urandom);
      step();
      check_model();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
